// File: rtl/xm_cpu_pkg.sv
// rtl/xm_cpu_pkg.sv - shared CPU types and constants for the fetch stage
package xm_cpu_pkg;

    localparam int             XM_WORD_W = 16;
    localparam logic [15:0]    PC_STEP   = 16'd2;

    typedef enum logic {
        IDLE,
        WAIT
    } fetch_state_t;

    typedef enum logic [1:0] {
        FF_NONE     = 2'b00,
        FF_MISALIGN = 2'b01,
        FF_TIMEOUT  = 2'b10
    } fetch_fault_t;

endpackage

// File: rtl/xm_instruction_fetch_unit_if.sv
// rtl/xm_instruction_fetch_unit_if.sv - req/ack instruction memory read port
interface xm_instruction_fetch_unit_if;
    import xm_cpu_pkg::*;

    logic                 mem_rd_req;
    logic [XM_WORD_W-1:0] mem_addr;
    logic [XM_WORD_W-1:0] mem_rdata;
    logic                 mem_ack;

    modport master (
        output mem_rd_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_rd_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/xm_instruction_fetch_unit.sv
// rtl/xm_instruction_fetch_unit.sv - PC holder and multi-cycle instruction fetch FSM
module xm_instruction_fetch_unit
    import xm_cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_start,
    input  logic                         i_pc_load,
    input  logic [XM_WORD_W-1:0]         i_pc_load_val,
    xm_instruction_fetch_unit_if.master  mem,
    output logic [XM_WORD_W-1:0]         o_inst_data,
    output logic                         o_inst_valid,
    output logic [XM_WORD_W-1:0]         o_inst_addr,
    output logic [XM_WORD_W-1:0]         o_pc,
    output logic                         o_busy,
    output logic                         o_fault,
    output logic [1:0]                   o_fault_cause
);

    localparam int TIMER_W = $clog2(TIMEOUT);

    fetch_state_t          r_state,       w_state_nxt;
    fetch_fault_t          r_cause,       w_cause_nxt;
    logic [XM_WORD_W-1:0]  r_pc,          w_pc_nxt;
    logic [XM_WORD_W-1:0]  r_addr,        w_addr_nxt;
    logic [XM_WORD_W-1:0]  r_inst_data,   w_inst_data_nxt;
    logic [XM_WORD_W-1:0]  r_inst_addr,   w_inst_addr_nxt;
    logic [XM_WORD_W-1:0]  r_pending_val, w_pending_val_nxt;
    logic [TIMER_W-1:0]    r_timer,       w_timer_nxt;
    logic                  r_req,         w_req_nxt;
    logic                  r_inst_valid,  w_inst_valid_nxt;
    logic                  r_fault,       w_fault_nxt;
    logic                  r_pending,     w_pending_nxt;
    logic [XM_WORD_W-1:0]  w_target;
    logic                  w_pend_eff;
    logic [XM_WORD_W-1:0]  w_pend_val_eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cause       <= FF_NONE;
            r_pc          <= RESET_PC;
            r_addr        <= '0;
            r_inst_data   <= '0;
            r_inst_addr   <= '0;
            r_pending_val <= '0;
            r_timer       <= '0;
            r_req         <= 1'b0;
            r_inst_valid  <= 1'b0;
            r_fault       <= 1'b0;
            r_pending     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cause       <= w_cause_nxt;
            r_pc          <= w_pc_nxt;
            r_addr        <= w_addr_nxt;
            r_inst_data   <= w_inst_data_nxt;
            r_inst_addr   <= w_inst_addr_nxt;
            r_pending_val <= w_pending_val_nxt;
            r_timer       <= w_timer_nxt;
            r_req         <= w_req_nxt;
            r_inst_valid  <= w_inst_valid_nxt;
            r_fault       <= w_fault_nxt;
            r_pending     <= w_pending_nxt;
        end
    end

    // A load arriving on the same cycle as completion must still redirect the PC.
    assign w_pend_eff     = i_pc_load | r_pending;
    assign w_pend_val_eff = i_pc_load ? i_pc_load_val : r_pending_val;
    assign w_target       = i_pc_load ? i_pc_load_val : r_pc;

    always_comb begin
        w_state_nxt       = r_state;
        w_cause_nxt       = FF_NONE;
        w_pc_nxt          = r_pc;
        w_addr_nxt        = r_addr;
        w_inst_data_nxt   = r_inst_data;
        w_inst_addr_nxt   = r_inst_addr;
        w_pending_val_nxt = r_pending_val;
        w_timer_nxt       = r_timer;
        w_req_nxt         = r_req;
        w_inst_valid_nxt  = 1'b0;
        w_fault_nxt       = 1'b0;
        w_pending_nxt     = r_pending;

        case (r_state)
            IDLE: begin
                if (i_pc_load) w_pc_nxt = i_pc_load_val;
                if (i_start) begin
                    if (w_target[0]) begin
                        w_fault_nxt = 1'b1;
                        w_cause_nxt = FF_MISALIGN;
                    end else begin
                        w_state_nxt = WAIT;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = w_target;
                        w_timer_nxt = '0;
                    end
                end
            end
            WAIT: begin
                w_timer_nxt = r_timer + TIMER_W'(1);
                if (i_pc_load) begin
                    w_pending_nxt     = 1'b1;
                    w_pending_val_nxt = i_pc_load_val;
                end
                if (mem.mem_ack) begin
                    w_inst_data_nxt  = mem.mem_rdata;
                    w_inst_addr_nxt  = r_addr;
                    w_inst_valid_nxt = 1'b1;
                    w_pc_nxt         = w_pend_eff ? w_pend_val_eff : r_addr + PC_STEP;
                    w_req_nxt        = 1'b0;
                    w_pending_nxt    = 1'b0;
                    w_state_nxt      = IDLE;
                end else if (r_timer == TIMER_W'(TIMEOUT - 1)) begin
                    w_fault_nxt   = 1'b1;
                    w_cause_nxt   = FF_TIMEOUT;
                    w_req_nxt     = 1'b0;
                    if (w_pend_eff) w_pc_nxt = w_pend_val_eff;
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign mem.mem_rd_req = r_req;
    assign mem.mem_addr   = r_addr;
    assign o_inst_data    = r_inst_data;
    assign o_inst_valid   = r_inst_valid;
    assign o_inst_addr    = r_inst_addr;
    assign o_pc           = r_pc;
    assign o_busy         = (r_state == WAIT);
    assign o_fault        = r_fault;
    assign o_fault_cause  = r_cause;

endmodule
